// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage with a DEPTH-entry circular fetch queue feeding decode.
// Holds the fetch PC, pushes {pc, insn} pairs, pops through an id_valid/id_ready
// handshake, and flushes/reloads on redirect.
// Optional macro FETCH_PERF_EN adds saturating perf_fetched / perf_stall counters.
module fetch_queue_stage #(
  parameter int unsigned PC_W   = 64,
  parameter int unsigned INSN_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PC_INC = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PC_W-1:0]          start_pc,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  output logic [PC_W-1:0]          imem_addr,
  input  logic [INSN_W-1:0]        imem_data,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [INSN_W-1:0]        id_insn,
  output logic [PC_W-1:0]          id_pc,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_stall
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [OccW-1:0] OccFull = OccW'(DEPTH);

  logic [PC_W-1:0]   pc_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [PtrW-1:0]   wr_ptr_q;
  logic [OccW-1:0]   occ_q;
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INSN_W-1:0] insn_mem [DEPTH];

  logic pop;
  logic push;

  // Handshake decode; a push into a full queue is allowed when the head leaves.
  always_comb begin
    id_valid  = (occ_q != '0);
    pop       = id_valid & id_ready & ~redirect;
    push      = ~redirect & ((occ_q < OccFull) | pop);
    imem_addr = pc_q;
    occupancy = occ_q;
    id_insn   = id_valid ? insn_mem[rd_ptr_q] : '0;
    id_pc     = id_valid ? pc_mem[rd_ptr_q]   : '0;
  end

  // PC, pointers and occupancy; reset beats redirect, redirect beats push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= start_pc;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else if (redirect) begin
      pc_q     <= redirect_pc;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        pc_q     <= pc_q + PC_W'(PC_INC);
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        occ_q <= occ_q + OccW'(1);
      end else if (pop && !push) begin
        occ_q <= occ_q - OccW'(1);
      end
    end
  end

  // Queue storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      pc_mem[wr_ptr_q]   <= pc_q;
      insn_mem[wr_ptr_q] <= imem_data;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q;
  logic [31:0] stall_q;

  // Saturating counters of pushes and of cycles lost to a full, non-draining queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      if (push && fetched_q != '1) begin
        fetched_q <= fetched_q + 32'd1;
      end
      if (!redirect && !push && stall_q != '1) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: directed vector table followed by
// randomized traffic compared against a queue-based reference model.
module tb_fetch_queue_stage;

  localparam int unsigned PC_W   = 64;
  localparam int unsigned INSN_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [PC_W-1:0]   start_pc;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic [PC_W-1:0]   imem_addr;
  logic [INSN_W-1:0] imem_data;
  logic              id_valid;
  logic              id_ready;
  logic [INSN_W-1:0] id_insn;
  logic [PC_W-1:0]   id_pc;
  logic [2:0]        occupancy;
`ifdef FETCH_PERF_EN
  logic [31:0]       perf_fetched;
  logic [31:0]       perf_stall;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [INSN_W-1:0] insn_of(input logic [PC_W-1:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'hDEAD_BEEF;
  endfunction

  // Instruction memory: combinational read of a fixed address hash.
  assign imem_data = insn_of(imem_addr);

  fetch_queue_stage #(
    .PC_W  (PC_W),
    .INSN_W(INSN_W),
    .DEPTH (DEPTH),
    .PC_INC(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_pc   (start_pc),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_insn    (id_insn),
    .id_pc      (id_pc),
    .occupancy  (occupancy)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall)
`endif
  );

  typedef struct {
    logic            rst;
    logic            redir;
    logic            rdy;
    logic [PC_W-1:0] spc;
    logic [PC_W-1:0] rpc;
    logic            e_valid;
    logic [PC_W-1:0] e_pc;
    logic [2:0]      e_occ;
    logic [PC_W-1:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic redir, input logic rdy,
                     input logic [PC_W-1:0] spc, input logic [PC_W-1:0] rpc,
                     input logic ev, input logic [PC_W-1:0] epc, input logic [2:0] eocc,
                     input logic [PC_W-1:0] eaddr);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rdy = rdy; v.spc = spc; v.rpc = rpc;
    v.e_valid = ev; v.e_pc = epc; v.e_occ = eocc; v.e_addr = eaddr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic ev, input logic [PC_W-1:0] epc,
                       input logic [2:0] eocc, input logic [PC_W-1:0] eaddr);
    logic [INSN_W-1:0] einsn;
    einsn = ev ? insn_of(epc) : '0;
    n_cmp++;
    if (id_valid !== ev || id_pc !== epc || id_insn !== einsn || occupancy !== eocc ||
        imem_addr !== eaddr) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b pc=%h insn=%h occ=%0d addr=%h, want valid=%0b pc=%h insn=%h occ=%0d addr=%h",
               name, id_valid, id_pc, id_insn, occupancy, imem_addr,
               ev, epc, einsn, eocc, eaddr);
    end
  endtask

  // Reference model state
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_q[$];
  int unsigned     m_fetched;
  int unsigned     m_stall;

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic popped;
    if (reset) begin
      m_q.delete();
      m_pc = start_pc;
      m_fetched = 0;
      m_stall = 0;
    end else if (redirect) begin
      m_q.delete();
      m_pc = redirect_pc;
    end else begin
      popped = (m_q.size() > 0) && id_ready;
      if (popped) void'(m_q.pop_front());
      if (m_q.size() < DEPTH) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 64'd4;
        m_fetched++;
      end else begin
        m_stall++;
      end
    end
  endtask

  initial begin
    logic [PC_W-1:0] w;
    reset = 1'b1; redirect = 1'b0; id_ready = 1'b0;
    start_pc = '0; redirect_pc = '0;
    w = 64'hFFFF_FFFF_FFFF_FFF8;

    // Sequential fetch with decode always ready
    add(1, 0, 1, 64'h1000, 0, 0, 0,         0, 64'h1000);
    add(0, 0, 1, 64'h1000, 0, 1, 64'h1000,  1, 64'h1004);
    add(0, 0, 1, 64'h1000, 0, 1, 64'h1004,  1, 64'h1008);
    add(0, 0, 1, 64'h1000, 0, 1, 64'h1008,  1, 64'h100C);
    // Backpressure fills the queue, PC stalls at 0x2010
    add(1, 0, 0, 64'h2000, 0, 0, 0,         0, 64'h2000);
    add(0, 0, 0, 64'h2000, 0, 1, 64'h2000,  1, 64'h2004);
    add(0, 0, 0, 64'h2000, 0, 1, 64'h2000,  2, 64'h2008);
    add(0, 0, 0, 64'h2000, 0, 1, 64'h2000,  3, 64'h200C);
    add(0, 0, 0, 64'h2000, 0, 1, 64'h2000,  4, 64'h2010);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 64'h2000, 0, 1, 64'h2000, 4, 64'h2010);
    // Full queue: simultaneous pop and push
    add(0, 0, 1, 64'h2000, 0, 1, 64'h2004,  4, 64'h2014);
    add(0, 0, 1, 64'h2000, 0, 1, 64'h2008,  4, 64'h2018);
    // Redirect with three entries queued and decode ready
    add(1, 0, 0, 64'h3000, 0, 0, 0,         0, 64'h3000);
    add(0, 0, 0, 64'h3000, 0, 1, 64'h3000,  1, 64'h3004);
    add(0, 0, 0, 64'h3000, 0, 1, 64'h3000,  2, 64'h3008);
    add(0, 0, 0, 64'h3000, 0, 1, 64'h3000,  3, 64'h300C);
    add(0, 1, 1, 64'h3000, 64'h4000, 0, 0,  0, 64'h4000);
    add(0, 0, 1, 64'h3000, 0, 1, 64'h4000,  1, 64'h4004);
    // PC wraps through zero
    add(1, 0, 1, w, 0, 0, 0,                0, w);
    add(0, 0, 1, w, 0, 1, w,                1, w + 64'd4);
    add(0, 0, 1, w, 0, 1, w + 64'd4,        1, 64'h0);
    add(0, 0, 1, w, 0, 1, 64'h0,            1, 64'h4);
    add(0, 0, 1, w, 0, 1, 64'h4,            1, 64'h8);
    // Reset and redirect together with two entries queued
    add(0, 0, 0, w, 0, 1, 64'h4,            2, 64'hC);
    add(1, 1, 0, 64'h6000, 64'h5000, 0, 0,  0, 64'h6000);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; redirect = vecs[i].redir; id_ready = vecs[i].rdy;
      start_pc = vecs[i].spc; redirect_pc = vecs[i].rpc;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_occ,
            vecs[i].e_addr);
    end

`ifdef FETCH_PERF_EN
    n_cmp++;
    if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
      n_bad++;
      $display("FAIL perf_reset: got fetched=%0d stall=%0d, want 0 0", perf_fetched, perf_stall);
    end
`endif

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset       = (c == 0) || ($urandom_range(63) == 0);
      redirect    = ($urandom_range(7) == 0);
      id_ready    = ($urandom_range(2) != 0);
      start_pc    = {$urandom, $urandom} & ~64'h3;
      redirect_pc = {$urandom, $urandom} & ~64'h3;
      model_step();
      @(posedge clk);
      #1;
      check($sformatf("rand%0d", c), m_q.size() > 0, (m_q.size() > 0) ? m_q[0] : '0,
            3'(m_q.size()), m_pc);
`ifdef FETCH_PERF_EN
      n_cmp++;
      if (perf_fetched !== m_fetched || perf_stall !== m_stall) begin
        n_bad++;
        $display("FAIL perf%0d: got fetched=%0d stall=%0d, want %0d %0d",
                 c, perf_fetched, perf_stall, m_fetched, m_stall);
      end
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
